// File: rtl/pwconv_result_packer.sv
// Packs per-channel conv-array results into four CH*DW-bit words per position and
// presents them to the output feature buffer through a single-entry valid/ready holding stage.
module pwconv_result_packer #(
  parameter int unsigned CH       = 32,
  parameter int unsigned DW       = 8,
  parameter int unsigned POS_W    = 4,
  parameter int unsigned LAST_POS = 15
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               clear,
  input  logic               en,
  input  logic [4:0]         cnt_in,
  input  logic [POS_W-1:0]   pos_in,
  input  logic [DW-1:0]      res_in0,
  input  logic [DW-1:0]      res_in1,
  input  logic [DW-1:0]      res_in2,
  input  logic [DW-1:0]      res_in3,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [POS_W-1:0]   wr_pos,
  output logic [0:CH*DW-1]   wr_data0,
  output logic [0:CH*DW-1]   wr_data1,
  output logic [0:CH*DW-1]   wr_data2,
  output logic [0:CH*DW-1]   wr_data3,
  output logic               frame_done,
  output logic               overflow,
  output logic               seq_err
);

  localparam int unsigned WW = CH * DW;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [DW-1:0]      res [4];
  logic [0:WW-1]      pack_q [4];
  logic [0:WW-1]      pack_d [4];
  logic [0:WW-1]      hold_q [4];
  logic [POS_W-1:0]   wr_pos_q;
  logic [4:0]         exp_cnt_q;
  logic               frame_done_q, overflow_q, seq_err_q;
  logic               complete, load, drop, handshake;

  assign res[0] = res_in0;
  assign res[1] = res_in1;
  assign res[2] = res_in2;
  assign res[3] = res_in3;

  assign complete = en && (cnt_in == 5'(CH - 1));

  // Merge this cycle's bytes so a completing word includes its last channel.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pack_d[k] = pack_q[k];
      if (en) begin
        for (int unsigned c = 0; c < CH; c++) begin
          if (cnt_in == 5'(c)) pack_d[k][c*DW +: DW] = res[k];
        end
      end
    end
  end

  // Holding FSM: state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StEmpty;
    end else if (clear) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Holding FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (complete) state_d = StFull;
      StFull:  if (wr_ready && !complete) state_d = StEmpty;
    endcase
  end

  // Holding FSM: outputs.
  always_comb begin
    wr_valid  = (state_q == StFull);
    handshake = wr_valid && wr_ready;
    load      = complete && (!wr_valid || wr_ready);
    drop      = complete && wr_valid && !wr_ready;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 4; k++) begin
        pack_q[k] <= '0;
        hold_q[k] <= '0;
      end
      wr_pos_q     <= '0;
      exp_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < 4; k++) begin
        pack_q[k] <= '0;
        hold_q[k] <= '0;
      end
      wr_pos_q     <= '0;
      exp_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        pack_q[k] <= pack_d[k];
        if (load) hold_q[k] <= pack_d[k];
      end
      if (load) wr_pos_q <= pos_in;
      frame_done_q <= handshake && (wr_pos_q == POS_W'(LAST_POS));
      if (drop) overflow_q <= 1'b1;
      // Resync to the observed count so one skip flags once, not every byte after.
      if (en) begin
        if (cnt_in != exp_cnt_q) seq_err_q <= 1'b1;
        exp_cnt_q <= complete ? 5'd0 : cnt_in + 5'd1;
      end
    end
  end

  assign wr_pos     = wr_pos_q;
  assign wr_data0   = hold_q[0];
  assign wr_data1   = hold_q[1];
  assign wr_data2   = hold_q[2];
  assign wr_data3   = hold_q[3];
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_pwconv_result_packer.sv
// Scoreboard bench for pwconv_result_packer: expected words are queued as positions are
// streamed in and compared at each write handshake.
module tb_pwconv_result_packer;

  localparam int NONE = 99;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         clear = 1'b0;
  logic         en = 1'b0;
  logic [4:0]   cnt_in = '0;
  logic [3:0]   pos_in = '0;
  logic [7:0]   res_in0 = '0, res_in1 = '0, res_in2 = '0, res_in3 = '0;
  logic         wr_valid, wr_ready = 1'b0;
  logic [3:0]   wr_pos;
  logic [0:255] wr_data0, wr_data1, wr_data2, wr_data3;
  logic         frame_done, overflow, seq_err;

  typedef struct {
    logic [3:0]   pos;
    logic [0:255] d0, d1, d2, d3;
  } word_t;

  word_t sb[$];
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int fd_count = 0;

  pwconv_result_packer #(.CH(32), .DW(8), .POS_W(4), .LAST_POS(15)) dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .en(en), .cnt_in(cnt_in), .pos_in(pos_in),
    .res_in0(res_in0), .res_in1(res_in1), .res_in2(res_in2), .res_in3(res_in3),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pos(wr_pos),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3),
    .frame_done(frame_done), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lane_byte(int lane, int seed, int c);
    case (lane)
      0:       return 8'(seed + c);
      1:       return 8'(8'hA0 + seed + c);
      2:       return 8'(8'h40 + 3 * c + seed);
      default: return 8'(8'hFF - c - seed);
    endcase
  endfunction

  function automatic logic [0:255] build(int lane, int seed, int skip);
    logic [0:255] w;
    w = '0;
    for (int c = 0; c < 32; c++) w[c*8 +: 8] = (c == skip) ? 8'h00 : lane_byte(lane, seed, c);
    return w;
  endfunction

  function automatic word_t make_word(int pos, int seed, int skip);
    word_t w;
    w.pos = 4'(pos);
    w.d0 = build(0, seed, skip);
    w.d1 = build(1, seed, skip);
    w.d2 = build(2, seed, skip);
    w.d3 = build(3, seed, skip);
    return w;
  endfunction

  // Handshake monitor: inputs change at posedge+1, so valid&&ready here is the next edge's write.
  always @(negedge clk) begin
    if (rst_b && wr_valid && wr_ready) begin
      word_t e;
      hs_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got pos %0d, expected no write", wr_pos);
      end else begin
        e = sb.pop_front();
        if (wr_pos !== e.pos || wr_data0 !== e.d0 || wr_data1 !== e.d1 ||
            wr_data2 !== e.d2 || wr_data3 !== e.d3) begin
          errors++;
          $display("FAIL sb_word: got pos %0d d0 %h d3 %h, expected pos %0d d0 %h d3 %h",
                   wr_pos, wr_data0, wr_data3, e.pos, e.d0, e.d3);
        end
      end
    end
  end

  always @(negedge clk) if (rst_b && frame_done) fd_count++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  // Caller is at posedge+1; returns at posedge+1 after the completing edge.
  task automatic send_pos(input int pos, input int seed, input int skip, input bit push,
                          input bit ready_last);
    if (push) sb.push_back(make_word(pos, seed, skip));
    for (int c = 0; c < 32; c++) begin
      if (c == skip) continue;
      en = 1'b1;
      cnt_in = 5'(c);
      pos_in = 4'(pos);
      res_in0 = lane_byte(0, seed, c);
      res_in1 = lane_byte(1, seed, c);
      res_in2 = lane_byte(2, seed, c);
      res_in3 = lane_byte(3, seed, c);
      if (ready_last && c == 31) wr_ready = 1'b1;
      @(posedge clk); #1;
    end
    en = 1'b0;
    if (ready_last) wr_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wr_valid, frame_done, overflow, seq_err} !== 4'b0 || wr_pos !== 4'd0 ||
        wr_data0 !== '0) begin
      errors++;
      $display("FAIL reset_initial: got v%b fd%b ov%b se%b pos %0d, expected all 0",
               wr_valid, frame_done, overflow, seq_err, wr_pos);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    send_pos(1, 5, NONE, 0, 0);
    send_pos(2, 6, NONE, 0, 0);
    checks++;
    if (wr_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_state: got v%b ov%b, expected v1 ov1", wr_valid, overflow);
    end
    for (int c = 0; c < 6; c++) begin
      en = 1'b1; cnt_in = 5'(c); res_in0 = 8'h55;
      @(posedge clk); #1;
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: got %b, expected 0", wr_valid);
    end
    checks++;
    if (overflow !== 1'b0 || seq_err !== 1'b0 || frame_done !== 1'b0 || wr_pos !== 4'd0 ||
        wr_data0 !== '0 || wr_data3 !== '0) begin
      errors++;
      $display("FAIL reset_async_state: got ov%b se%b fd%b pos %0d, expected all 0",
               overflow, seq_err, frame_done, wr_pos);
    end
    en = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic test_single();
    wr_ready = 1'b1;
    send_pos(3, 0, NONE, 1, 0);
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b1 || wr_pos !== 4'd3) begin
      errors++;
      $display("FAIL single_valid: got v%b pos %0d, expected v1 pos 3", wr_valid, wr_pos);
    end
    checks++;
    if (wr_data0[0:7] !== 8'h00 || wr_data0[248:255] !== 8'd31 ||
        wr_data1[248:255] !== 8'hBF) begin
      errors++;
      $display("FAIL single_bytes: got %h %h %h, expected 00 1f bf",
               wr_data0[0:7], wr_data0[248:255], wr_data1[248:255]);
    end
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_drop: got %b, expected 0", wr_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    word_t first;
    wr_ready = 1'b0;
    first = make_word(5, 1, NONE);
    send_pos(5, 1, NONE, 1, 0);
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b1 || wr_pos !== 4'd5 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_held: got v%b pos %0d ov%b, expected v1 pos 5 ov0",
               wr_valid, wr_pos, overflow);
    end
    @(posedge clk); #1;
    send_pos(6, 2, NONE, 0, 0);
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || wr_pos !== 4'd5 || wr_data0 !== first.d0 ||
        wr_data3 !== first.d3) begin
      errors++;
      $display("FAIL bp_overflow: got ov%b pos %0d d0 %h, expected ov1 pos 5 d0 %h",
               overflow, wr_pos, wr_data0, first.d0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got v%b pending %0d, expected v0 pending 0", wr_valid, sb.size());
    end
    @(posedge clk); #1;
    do_clear();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    wr_ready = 1'b0;
    send_pos(7, 3, NONE, 1, 0);
    send_pos(8, 4, NONE, 1, 1);
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b1 || wr_pos !== 4'd8 || overflow !== 1'b0 ||
        wr_data1 !== build(1, 4, NONE)) begin
      errors++;
      $display("FAIL b2b_switch: got v%b pos %0d ov%b, expected v1 pos 8 ov0",
               wr_valid, wr_pos, overflow);
    end
    checks++;
    if (sb.size() != 1) begin
      errors++;
      $display("FAIL b2b_first_written: got %0d pending, expected 1", sb.size());
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b, expected 0", wr_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    int hs_start;
    checks++;
    if (fd_count != 0) begin
      errors++;
      $display("FAIL frame_done_early: got %0d pulses, expected 0", fd_count);
    end
    wr_ready = 1'b1;
    hs_start = hs_count;
    for (int p = 0; p < 16; p++) send_pos(p, 10 + p, NONE, 1, 0);
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_pre_hs: got v%b fd%b, expected v1 fd0", wr_valid, frame_done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_pulse: got %b, expected 1", frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || fd_count != 1 || hs_count - hs_start != 16) begin
      errors++;
      $display("FAIL frame_counts: got fd%b pulses %0d writes %0d, expected fd0 1 16",
               frame_done, fd_count, hs_count - hs_start);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    do_clear();
    wr_ready = 1'b1;
    sb.push_back(make_word(9, 20, 3));
    for (int c = 0; c < 32; c++) begin
      if (c == 3) continue;
      en = 1'b1; cnt_in = 5'(c); pos_in = 4'd9;
      res_in0 = lane_byte(0, 20, c);
      res_in1 = lane_byte(1, 20, c);
      res_in2 = lane_byte(2, 20, c);
      res_in3 = lane_byte(3, 20, c);
      @(posedge clk); #1;
      if (c == 2) begin
        checks++;
        if (seq_err !== 1'b0) begin
          errors++;
          $display("FAIL seq_before_skip: got %b, expected 0", seq_err);
        end
      end
      if (c == 4) begin
        checks++;
        if (seq_err !== 1'b1) begin
          errors++;
          $display("FAIL seq_after_skip: got %b, expected 1", seq_err);
        end
      end
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (seq_err !== 1'b1) begin
      errors++;
      $display("FAIL seq_sticky: got %b, expected 1", seq_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_clear();
    checks++;
    if (seq_err !== 1'b0) begin
      errors++;
      $display("FAIL seq_clear: got %b, expected 0", seq_err);
    end
    send_pos(10, 30, NONE, 1, 0);
    @(posedge clk); #1;
    checks++;
    if (seq_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL seq_clean_pos: got se%b ov%b, expected 0 0", seq_err, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_frame();
    test_sequence();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending words, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
